// File: rtl/serial_pattern_detector.sv
// serial_pattern_detector: compares the most recent len qualified serial bits
// against a run-time programmable pattern (len = 1..MAX_LEN), with overlapping
// or non-overlapping match modes. Outputs a registered one-cycle DETECT pulse,
// an armed flag and a saturating match counter.
// Optional feature macro: PATDET_COUNT_EN builds the match counter; when it is
// undefined match_count is tied to zero and no counter flops exist.
module serial_pattern_detector #(
  parameter int                 MAX_LEN     = 8,
  parameter int                 LEN_W       = $clog2(MAX_LEN+1),
  parameter int                 CNT_W       = 16,
  parameter logic [MAX_LEN-1:0] RST_PATTERN = MAX_LEN'('b0101),
  parameter int                 RST_LEN     = 4,
  parameter bit                 RST_OVERLAP = 1'b1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in,
  input  logic               in_valid,
  input  logic               cfg_load,
  input  logic [MAX_LEN-1:0] cfg_pattern,
  input  logic [LEN_W-1:0]   cfg_len,
  input  logic               cfg_overlap,
  output logic               DETECT,
  output logic               armed,
  output logic [CNT_W-1:0]   match_count
);

  typedef enum logic {FILL = 1'b0, ARMED = 1'b1} state_t;

  localparam logic [MAX_LEN:0] ONE = (MAX_LEN+1)'(1);

  // Lengths outside 1..MAX_LEN are pulled back into range.
  function automatic logic [LEN_W-1:0] clamp_len(input int l);
    if (l < 1)            return LEN_W'(1);
    else if (l > MAX_LEN) return LEN_W'(MAX_LEN);
    else                  return LEN_W'(l);
  endfunction

  logic [MAX_LEN-1:0] hist_q, hist_d;
  logic [MAX_LEN-1:0] pat_q, pat_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               ovl_q, ovl_d;
  logic [LEN_W-1:0]   fill_q, fill_d, fill_inc;
  state_t             state_q, state_d;
  logic               det_q, det_d;
  logic               hit;
  logic               full;
  logic [MAX_LEN:0]   mask_w;

  // Next-state: cfg_load has priority over a valid bit; bubbles hold everything.
  always_comb begin
    hist_d   = hist_q;
    pat_d    = pat_q;
    len_d    = len_q;
    ovl_d    = ovl_q;
    fill_d   = fill_q;
    state_d  = state_q;
    det_d    = 1'b0;
    hit      = 1'b0;
    full     = 1'b0;
    fill_inc = (fill_q == len_q) ? len_q : fill_q + LEN_W'(1);
    // Ones in bits [len-1:0]; computed one bit wider so len == MAX_LEN is safe.
    mask_w   = (ONE << len_q) - ONE;
    if (cfg_load) begin
      pat_d   = cfg_pattern;
      len_d   = clamp_len(int'(cfg_len));
      ovl_d   = cfg_overlap;
      hist_d  = '0;
      fill_d  = '0;
      state_d = FILL;
    end else if (in_valid) begin
      hist_d = {hist_q[MAX_LEN-2:0], in};
      fill_d = fill_inc;
      full   = (fill_inc == len_q);
      hit    = full && (((hist_d ^ pat_q) & mask_w[MAX_LEN-1:0]) == '0);
      det_d  = hit;
      if (hit && !ovl_q) begin
        // Non-overlap: the next match must be built from fresh bits only.
        fill_d  = '0;
        state_d = FILL;
      end else if (full) begin
        state_d = ARMED;
      end
    end
  end

  // Registered configuration, history, fill count, FSM and DETECT.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist_q  <= '0;
      pat_q   <= RST_PATTERN;
      len_q   <= clamp_len(RST_LEN);
      ovl_q   <= RST_OVERLAP;
      fill_q  <= '0;
      state_q <= FILL;
      det_q   <= 1'b0;
    end else begin
      hist_q  <= hist_d;
      pat_q   <= pat_d;
      len_q   <= len_d;
      ovl_q   <= ovl_d;
      fill_q  <= fill_d;
      state_q <= state_d;
      det_q   <= det_d;
    end
  end

  assign DETECT = det_q;
  assign armed  = (state_q == ARMED);

`ifdef PATDET_COUNT_EN
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Saturating match counter, cleared by cfg_load.
  always_comb begin
    cnt_d = cnt_q;
    if (cfg_load)                 cnt_d = '0;
    else if (hit && cnt_q != '1)  cnt_d = cnt_q + CNT_W'(1);
  end

  // Counter register.
  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign match_count = cnt_q;
`else
  assign match_count = '0;
`endif

endmodule
